// File: rtl/crypto_pkg.sv
// Shared op codes, FSM state encoding and helpers for the crypto operation responder.
package crypto_pkg;

   localparam int NUM_ENGINES = 4;
   localparam int OPERAND_W   = 128;

   localparam logic [1:0] OP_RSA_E = 2'd0;
   localparam logic [1:0] OP_RSA_D = 2'd1;
   localparam logic [1:0] OP_AES_E = 2'd2;
   localparam logic [1:0] OP_AES_D = 2'd3;

   localparam logic [OPERAND_W-1:0] OPERAND_TERMINATOR = 128'd1;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      WRITE,
      HOLD
   } state_t;

   // Only meaningful when exactly one flag is set; the caller qualifies with a one-hot check.
   function automatic logic [1:0] op_from_flags(input logic [NUM_ENGINES-1:0] f);
      logic [1:0] op;
      op = OP_RSA_E;
      if (f[OP_RSA_D]) op = OP_RSA_D;
      if (f[OP_AES_E]) op = OP_AES_E;
      if (f[OP_AES_D]) op = OP_AES_D;
      return op;
   endfunction

   function automatic logic [NUM_ENGINES-1:0] op_onehot(input logic [1:0] op);
      return NUM_ENGINES'(1) << op;
   endfunction

endpackage

// File: rtl/crypto_op_timer.sv
// Engine watchdog: counts cycles while enabled, reports expiry at TIMEOUT_CYCLES-1.
module crypto_op_timer #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/crypto_op_responder.sv
// Turns control-path op requests into engine starts, waits for completion, writes the
// engine result to result memory and holds the matching done level for the control path.
module crypto_op_responder
   import crypto_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rsa_enc_flag,
   input  logic                   rsa_dec_flag,
   input  logic                   aes_enc_flag,
   input  logic                   aes_dec_flag,
   input  logic [127:0]           operand_in,
   input  logic                   new_data,
   output logic [3:0]             eng_start,
   output logic [127:0]           eng_operand,
   input  logic [3:0]             eng_done,
   input  logic [127:0]           eng_result,
   output logic                   rsa_encdone,
   output logic                   rsa_decdone,
   output logic                   aes_encdone,
   output logic                   aes_decdone,
   output logic                   result_wr_en,
   output logic [ADDR_W-1:0]      result_wr_addr,
   output logic [127:0]           result_wr_data,
   output logic                   busy,
   output logic                   err_multi,
   output logic                   err_timeout
);

   state_t                 state;
   logic [NUM_ENGINES-1:0] flags;
   logic [NUM_ENGINES-1:0] flags_prev;
   logic [NUM_ENGINES-1:0] flag_rise;
   logic [NUM_ENGINES-1:0] done_q;
   logic [1:0]             op_q;
   logic [1:0]             op_sel;
   logic [ADDR_W-1:0]      wr_ptr;
   logic                   req;
   logic                   multi;
   logic                   accept;
   logic                   expired;

   assign flags     = {aes_dec_flag, aes_enc_flag, rsa_dec_flag, rsa_enc_flag};
   assign flag_rise = flags & ~flags_prev;
   assign req       = (|flag_rise) || (new_data && (|flags));
   assign multi     = !$onehot0(flags);
   assign op_sel    = op_from_flags(flags);
   // A launchable request: a single flag and a real operand (not the stream terminator).
   assign accept    = $onehot(flags) && (operand_in != OPERAND_TERMINATOR);

   crypto_op_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == LAUNCH),
      .enable (state == WAIT),
      .expired(expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         flags_prev     <= '0;
         op_q           <= OP_RSA_E;
         wr_ptr         <= '0;
         done_q         <= '0;
         eng_start      <= '0;
         eng_operand    <= '0;
         result_wr_en   <= 1'b0;
         result_wr_addr <= '0;
         result_wr_data <= '0;
         busy           <= 1'b0;
         err_multi      <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         flags_prev   <= flags;
         eng_start    <= '0;
         result_wr_en <= 1'b0;
         err_multi    <= 1'b0;
         err_timeout  <= 1'b0;

         case (state)
            IDLE: begin
               if (req) begin
                  if (multi) begin
                     err_multi <= 1'b1;
                  end else if (accept) begin
                     op_q        <= op_sel;
                     eng_operand <= operand_in;
                     eng_start   <= op_onehot(op_sel);
                     busy        <= 1'b1;
                     state       <= LAUNCH;
                  end
               end
            end

            LAUNCH: begin
               state <= WAIT;
            end

            // Engine completion wins over a timeout landing in the same cycle.
            WAIT: begin
               if (eng_done[op_q]) begin
                  result_wr_data <= eng_result;
                  result_wr_addr <= wr_ptr;
                  result_wr_en   <= 1'b1;
                  wr_ptr         <= wr_ptr + 1'b1;
                  state          <= WRITE;
               end else if (expired) begin
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  done_q      <= op_onehot(op_q);
                  state       <= HOLD;
               end
            end

            WRITE: begin
               busy   <= 1'b0;
               done_q <= op_onehot(op_q);
               state  <= HOLD;
            end

            // A dropped flag takes priority over a fresh operand arriving alongside it.
            HOLD: begin
               if (!flags[op_q]) begin
                  done_q <= '0;
                  state  <= IDLE;
               end else if (new_data) begin
                  if (multi) begin
                     err_multi <= 1'b1;
                  end else if (accept) begin
                     done_q      <= '0;
                     op_q        <= op_sel;
                     eng_operand <= operand_in;
                     eng_start   <= op_onehot(op_sel);
                     busy        <= 1'b1;
                     state       <= LAUNCH;
                  end
               end
            end

            default: begin
               done_q <= '0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign rsa_encdone = done_q[OP_RSA_E];
   assign rsa_decdone = done_q[OP_RSA_D];
   assign aes_encdone = done_q[OP_AES_E];
   assign aes_decdone = done_q[OP_AES_D];

endmodule

// File: tb/tb_crypto_op_responder.sv
// Directed bench for crypto_op_responder with a timestamp-based reference model.
module tb_crypto_op_responder;

   localparam int AW = 2;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           rsa_enc_flag = 1'b0;
   logic           rsa_dec_flag = 1'b0;
   logic           aes_enc_flag = 1'b0;
   logic           aes_dec_flag = 1'b0;
   logic [127:0]   operand_in = '0;
   logic           new_data = 1'b0;
   logic [3:0]     eng_start;
   logic [127:0]   eng_operand;
   logic [3:0]     eng_done = '0;
   logic [127:0]   eng_result = '0;
   logic           rsa_encdone, rsa_decdone, aes_encdone, aes_decdone;
   logic           result_wr_en;
   logic [AW-1:0]  result_wr_addr;
   logic [127:0]   result_wr_data;
   logic           busy, err_multi, err_timeout;

   int n_cmp = 0;
   int n_bad = 0;

   crypto_op_responder #(
      .ADDR_W(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .rsa_enc_flag(rsa_enc_flag), .rsa_dec_flag(rsa_dec_flag),
      .aes_enc_flag(aes_enc_flag), .aes_dec_flag(aes_dec_flag),
      .operand_in(operand_in), .new_data(new_data),
      .eng_start(eng_start), .eng_operand(eng_operand),
      .eng_done(eng_done), .eng_result(eng_result),
      .rsa_encdone(rsa_encdone), .rsa_decdone(rsa_decdone),
      .aes_encdone(aes_encdone), .aes_decdone(aes_decdone),
      .result_wr_en(result_wr_en), .result_wr_addr(result_wr_addr),
      .result_wr_data(result_wr_data),
      .busy(busy), .err_multi(err_multi), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Reference model: an operation is described by the edge it was accepted on.
   int           m_cyc = 0;
   logic [3:0]   m_prev = '0;
   bit           m_active = 0;
   bit           m_write = 0;
   bit           m_hold = 0;
   int           m_launch_edge = 0;
   int           m_op = 0;
   int           m_ptr = 0;
   logic [127:0] m_operand = '0;

   logic [3:0]    x_start = '0;
   logic [3:0]    x_done = '0;
   bit            x_busy = 0, x_wr = 0, x_multi = 0, x_timeout = 0;
   logic [AW-1:0] x_addr = '0;
   logic [127:0]  x_data = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_launch(input logic [3:0] f);
      for (int i = 0; i < 4; i++) if (f[i]) m_op = i;
      m_active      = 1;
      m_launch_edge = m_cyc;
      m_operand     = operand_in;
      x_start       = 4'(1) << m_op;
   endtask

   task automatic model_step();
      logic [3:0] f;
      logic [3:0] rise;
      bit         req;
      int         nf;
      if (reset) begin
         m_prev = '0; m_active = 0; m_write = 0; m_hold = 0; m_ptr = 0; m_operand = '0;
         x_start = '0; x_done = '0; x_busy = 0; x_wr = 0; x_multi = 0; x_timeout = 0;
         x_addr = '0; x_data = '0;
         return;
      end
      m_cyc++;
      f    = {aes_dec_flag, aes_enc_flag, rsa_dec_flag, rsa_enc_flag};
      rise = f & ~m_prev;
      req  = (|rise) || (new_data && (|f));
      nf   = $countones(f);
      x_start = '0; x_wr = 0; x_multi = 0; x_timeout = 0;
      if (m_write) begin
         m_write = 0;
         m_hold  = 1;
      end else if (m_active) begin
         if (m_cyc >= m_launch_edge + 2) begin
            if (eng_done[m_op]) begin
               m_active = 0; m_write = 1; x_wr = 1;
               x_addr = AW'(m_ptr); x_data = eng_result;
               m_ptr = (m_ptr + 1) % (1 << AW);
            end else if (m_cyc == m_launch_edge + 1 + TO) begin
               m_active = 0; m_hold = 1; x_timeout = 1;
            end
         end
      end else if (m_hold) begin
         if (!f[m_op]) m_hold = 0;
         else if (new_data) begin
            if (nf > 1) x_multi = 1;
            else if (operand_in != 128'd1) begin
               m_hold = 0;
               m_launch(f);
            end
         end
      end else if (req) begin
         if (nf > 1) x_multi = 1;
         else if (operand_in != 128'd1) m_launch(f);
      end
      m_prev = f;
      x_busy = m_active || m_write;
      x_done = m_hold ? (4'(1) << m_op) : 4'd0;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("eng_start", 128'(eng_start), 128'(x_start));
         check("done_lines", 128'({aes_decdone, aes_encdone, rsa_decdone, rsa_encdone}), 128'(x_done));
         check("busy", 128'(busy), 128'(x_busy));
         check("wr_en", 128'(result_wr_en), 128'(x_wr));
         check("err_multi", 128'(err_multi), 128'(x_multi));
         check("err_timeout", 128'(err_timeout), 128'(x_timeout));
         if (x_wr) begin
            check("wr_addr", 128'(result_wr_addr), 128'(x_addr));
            check("wr_data", result_wr_data, x_data);
         end
         if (x_busy) check("eng_operand", eng_operand, m_operand);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_start(input int op);
      int n = 0;
      while (!eng_start[op] && n < 40) begin
         tick();
         n++;
      end
      check("start_seen", 128'(eng_start[op]), 128'(1));
   endtask

   task automatic pulse_done(input logic [3:0] d, input logic [127:0] r);
      eng_done   = d;
      eng_result = r;
      tick();
      eng_done   = '0;
   endtask

   task automatic pulse_nd(input logic [127:0] op_val);
      new_data   = 1'b1;
      operand_in = op_val;
      tick();
      new_data   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick();
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_start", 128'(eng_start), 128'(0));
      check("rst_done", 128'({aes_decdone, aes_encdone, rsa_decdone, rsa_encdone}), 128'(0));
      reset = 1'b0;
      tick();

      // 1: AES_E, engine answers 10 cycles after start
      aes_enc_flag = 1'b1;
      operand_in   = {16{8'hA5}};
      tick();
      check("t1_start", 128'(eng_start), 128'(4'b0100));
      check("t1_operand", eng_operand, {16{8'hA5}});
      tick();
      check("t1_start_1cyc", 128'(eng_start), 128'(0));
      repeat (9) tick();
      pulse_done(4'b0100, 128'h1234);
      check("t1_wr_en", 128'(result_wr_en), 128'(1));
      check("t1_wr_addr", 128'(result_wr_addr), 128'(0));
      check("t1_wr_data", result_wr_data, 128'h1234);
      tick();
      check("t1_done", 128'(aes_encdone), 128'(1));
      repeat (3) tick();
      check("t1_done_held", 128'(aes_encdone), 128'(1));
      aes_enc_flag = 1'b0;
      tick();
      check("t1_done_drop", 128'(aes_encdone), 128'(0));

      // 2: back-to-back operands via new_data in HOLD
      do_reset();
      rsa_dec_flag = 1'b1;
      operand_in   = 128'd2;
      tick();
      wait_start(1);
      repeat (3) tick();
      pulse_done(4'b0010, 128'h20);
      check("t2_addr0", 128'(result_wr_addr), 128'(0));
      tick();
      check("t2_done_a", 128'(rsa_decdone), 128'(1));
      pulse_nd(128'd3);
      check("t2_done_dropped", 128'(rsa_decdone), 128'(0));
      wait_start(1);
      repeat (2) tick();
      pulse_done(4'b0010, 128'h30);
      check("t2_addr1", 128'(result_wr_addr), 128'(1));
      tick();
      pulse_nd(128'd4);
      wait_start(1);
      repeat (5) tick();
      pulse_done(4'b0010, 128'h40);
      check("t2_addr2", 128'(result_wr_addr), 128'(2));
      check("t2_data2", result_wr_data, 128'h40);
      tick();
      rsa_dec_flag = 1'b0;
      tick();

      // 3: terminator operand
      do_reset();
      aes_dec_flag = 1'b1;
      operand_in   = 128'd1;
      tick();
      check("t3_no_start", 128'(eng_start), 128'(0));
      repeat (3) tick();
      check("t3_no_busy", 128'(busy), 128'(0));
      check("t3_no_done", 128'(aes_decdone), 128'(0));
      aes_dec_flag = 1'b0;
      tick();

      // 4a: two flags at once
      rsa_enc_flag = 1'b1;
      rsa_dec_flag = 1'b1;
      operand_in   = 128'd5;
      tick();
      check("t4_multi", 128'(err_multi), 128'(1));
      check("t4_no_start", 128'(eng_start), 128'(0));
      tick();
      check("t4_multi_1cyc", 128'(err_multi), 128'(0));
      rsa_enc_flag = 1'b0;
      rsa_dec_flag = 1'b0;
      tick();

      // 4b: stray engine done for another op
      do_reset();
      rsa_enc_flag = 1'b1;
      operand_in   = 128'd7;
      tick();
      wait_start(0);
      repeat (2) tick();
      pulse_done(4'b0010, 128'hDEAD);
      check("t4_stray_no_wr", 128'(result_wr_en), 128'(0));
      check("t4_stray_busy", 128'(busy), 128'(1));
      pulse_done(4'b0001, 128'hBEEF);
      check("t4_wr_data", result_wr_data, 128'hBEEF);
      tick();
      check("t4_done", 128'(rsa_encdone), 128'(1));
      rsa_enc_flag = 1'b0;
      tick();

      // 5: engine never completes
      do_reset();
      aes_dec_flag = 1'b1;
      operand_in   = 128'd9;
      tick();
      wait_start(3);
      repeat (16) tick();
      check("t5_not_yet", 128'(err_timeout), 128'(0));
      tick();
      check("t5_timeout", 128'(err_timeout), 128'(1));
      check("t5_no_wr", 128'(result_wr_en), 128'(0));
      check("t5_done", 128'(aes_decdone), 128'(1));
      tick();
      check("t5_timeout_1cyc", 128'(err_timeout), 128'(0));
      aes_dec_flag = 1'b0;
      tick();

      // 6: pointer wrap, then reset in WAIT
      do_reset();
      rsa_enc_flag = 1'b1;
      operand_in   = 128'd100;
      tick();
      wait_start(0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            pulse_nd(128'(100 + i));
            wait_start(0);
         end
         repeat (1 + i) tick();
         pulse_done(4'b0001, 128'(8'hC0 + i));
         check("t6_wrap_addr", 128'(result_wr_addr), 128'(i % 4));
         tick();
      end
      pulse_nd(128'd200);
      wait_start(0);
      repeat (3) tick();
      reset        = 1'b1;
      rsa_enc_flag = 1'b0;
      #1;
      check("t6_rst_busy", 128'(busy), 128'(0));
      check("t6_rst_operand", eng_operand, 128'd0);
      check("t6_rst_addr", 128'(result_wr_addr), 128'(0));
      check("t6_rst_data", result_wr_data, 128'd0);
      tick();
      reset = 1'b0;
      tick();
      pulse_done(4'b0001, 128'hFF);
      check("t6_late_no_wr", 128'(result_wr_en), 128'(0));
      check("t6_late_no_busy", 128'(busy), 128'(0));
      tick();
      check("t6_late_no_done", 128'(rsa_encdone), 128'(0));
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/crypto_op_responder.md
# crypto_op_responder

Engine-side responder for the crypto processor control path. The control path raises one of four operation-request flags (RSA encrypt/decrypt, AES encrypt/decrypt) with a 128-bit operand. This block turns each request into a one-cycle start to the matching engine and waits for that engine to finish. It then writes the engine result to the result memory and holds the matching done line to the control path until the request is withdrawn or the next operand arrives.

## Interface
- `ADDR_W`, default 8: result-memory address width; the write pointer wraps at 2^ADDR_W.
- `TIMEOUT_CYCLES`, default 4096: maximum number of cycles spent in WAIT before the operation is aborted.

- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `rsa_enc_flag`, `rsa_dec_flag`, `aes_enc_flag`, `aes_dec_flag` in 1 each: level request flags from the control path.
- `operand_in` in 128: operand; valid whenever a request is sampled.
- `new_data` in 1: one-cycle pulse meaning a fresh operand is on `operand_in` while a flag stays high.
- `eng_start` out 4: one-hot engine start pulse, bit index = op code.
- `eng_operand` out 128: latched operand, held stable from LAUNCH through WAIT.
- `eng_done` in 4: engine completion pulses, bit index = op code.
- `eng_result` in 128: engine result, valid in the cycle any `eng_done` bit is high.
- `rsa_encdone`, `rsa_decdone`, `aes_encdone`, `aes_decdone` out 1 each: done levels returned to the control path.
- `result_wr_en` out 1, `result_wr_addr` out ADDR_W, `result_wr_data` out 128: result-memory write port.
- `busy` out 1: high in LAUNCH, WAIT and WRITE.
- `err_multi` out 1: one-cycle pulse when a request is sampled with more than one flag high.
- `err_timeout` out 1: one-cycle pulse when an engine times out.

## Operation
- **Op code**: RSA_E=0, RSA_D=1, AES_E=2, AES_D=3, matching the control path's encoding.
- **Request**: a rising edge on any flag, or `new_data`=1 while a flag is high.
- **Request checks**:
  - Exactly one flag high: the request is valid.
  - More than one flag high: pulse `err_multi`, stay in IDLE.
  - `operand_in` == 128'd1 (terminator): no launch, no write, no done; stay in IDLE.
- **States**:
  - IDLE: on a valid request, latch the op code and operand, go to LAUNCH.
  - LAUNCH: assert `eng_start[op]` for 1 cycle, clear the timer, go to WAIT.
  - WAIT:
    - `eng_done[op]`=1: capture `eng_result`, go to WRITE.
    - Other `eng_done` bits: ignored.
    - Timer reaches TIMEOUT_CYCLES-1: pulse `err_timeout`, go to HOLD without a write.
  - WRITE: `result_wr_en`=1 for 1 cycle with `result_wr_addr`=wr_ptr; wr_ptr increments (wraps from 2^ADDR_W-1 to 0); go to HOLD.
  - HOLD: done line for the latched op is held at 1.
    - Flag for the op drops: go to IDLE.
    - `new_data` pulse with a valid request: go directly to LAUNCH, with the new operand latched. The done line drops in that same transition.
- **Requests while busy**: flag edges and `new_data` seen in LAUNCH, WAIT or WRITE are ignored.
- **Reset mid-operation**: return to IDLE, wr_ptr=0. An engine done arriving after reset is ignored.

## Timing
- **Reset values**: every output is 0, including all done lines, `eng_start`, `busy` and both error pulses.
- **Start latency**: request sampled at edge 0 → `eng_start` high in the cycle after edge 0 → state WAIT from edge 1.
- **Done latency**: `eng_done` sampled at edge k → `result_wr_en` high in the cycle after edge k → done line high from edge k+1.
- **Total latency**: request to done is 3 cycles plus the engine's latency.
- **Simultaneous engine done and timeout**: the engine done takes priority.
- **Simultaneous flag drop and `new_data` in HOLD**: the flag drop takes priority; the block returns to IDLE.
- **Outputs**: all outputs are registered.

## Structure
- **Package `crypto_pkg`**:
  - op code localparams.
  - OPERAND_TERMINATOR = 128'd1.
  - state enum (IDLE, LAUNCH, WAIT, WRITE, HOLD).
  - NUM_ENGINES = 4.
- **Sub-module `crypto_op_timer`**: a clear/enable counter with a `expired` output at TIMEOUT_CYCLES-1. Everything else is the FSM plus the datapath registers.

## Test plan
1. AES_E request: raise `aes_enc_flag` with operand 0xA5..A5; engine done 10 cycles after start with result 0x1234 → `eng_start`=4'b0100 for 1 cycle; write at addr 0 with data 0x1234; `aes_encdone` high until the flag drops.
2. Back-to-back operands: three `new_data` pulses each arriving in HOLD, operands 2, 3, 4 → three writes at addrs 0, 1, 2; done drops between operations.
3. Terminator: request with operand 128'd1 → no `eng_start`, no write, all done lines stay 0.
4. Invalid requests and stray dones:
   - `rsa_enc_flag` and `rsa_dec_flag` raised in the same cycle → `err_multi` pulses once, no launch.
   - In a separate run, `eng_done[1]` arriving while the op is RSA_E → ignored.
5. Timeout: with TIMEOUT_CYCLES=16, the engine never completes → `err_timeout` pulses 16 cycles after entering WAIT, no write, done line high in HOLD.
6. Wrap and reset: with ADDR_W=2, five operations → writes at 0, 1, 2, 3, 0; then reset asserted during WAIT → all outputs 0 immediately and the late `eng_done` is ignored.
